// File: rtl/fetch_predecode.sv
// fetch_predecode: registers one icache fetch block, pre-decodes JAL/JALR/BR, corrects bad predictions via a redirect, and forwards lanes to the ibuf
module fetch_predecode #(
  parameter int BLOCK_INST_SIZE  = 8,
  parameter int PREDICTION_WIDTH = 3,
  parameter int VADDR_SIZE       = 39,
  parameter int FSQ_WIDTH        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BLOCK_INST_SIZE-1:0]    in_en,
  input  logic [BLOCK_INST_SIZE-1:0]    in_exception,
  input  logic [BLOCK_INST_SIZE*32-1:0] in_data,
  input  logic [VADDR_SIZE-1:0]         in_start_addr,
  input  logic [PREDICTION_WIDTH-1:0]   in_size,
  input  logic                          in_taken,
  input  logic [VADDR_SIZE-1:0]         in_target,
  input  logic [FSQ_WIDTH-1:0]          in_fsq_idx,
  input  logic                          flush,
  output logic                          stall,
  input  logic                          ibuf_ready,
  output logic [BLOCK_INST_SIZE-1:0]    out_en,
  output logic [BLOCK_INST_SIZE*32-1:0] out_data,
  output logic [BLOCK_INST_SIZE-1:0]    out_exception,
  output logic [VADDR_SIZE-1:0]         out_pc,
  output logic [FSQ_WIDTH-1:0]          out_fsq_idx,
  output logic                          redirect_valid,
  output logic [FSQ_WIDTH-1:0]          redirect_fsq_idx,
  output logic [VADDR_SIZE-1:0]         redirect_pc,
  output logic [PREDICTION_WIDTH-1:0]   redirect_size
);
  logic                          r_valid;
  logic [BLOCK_INST_SIZE-1:0]    r_en;
  logic [BLOCK_INST_SIZE-1:0]    r_exc;
  logic [BLOCK_INST_SIZE*32-1:0] r_data;
  logic [VADDR_SIZE-1:0]         r_pc;
  logic [VADDR_SIZE-1:0]         r_target;
  logic [PREDICTION_WIDTH-1:0]   r_size;
  logic                          r_taken;
  logic [FSQ_WIDTH-1:0]          r_fsq;
  logic [BLOCK_INST_SIZE-1:0]    w_jal;
  logic [BLOCK_INST_SIZE-1:0]    w_none;
  logic [VADDR_SIZE-1:0]         w_tgt [BLOCK_INST_SIZE];
  logic [BLOCK_INST_SIZE-1:0]    w_mask;
  logic                          w_hit;
  logic [VADDR_SIZE-1:0]         w_rpc;
  logic [PREDICTION_WIDTH-1:0]   w_rsize;
  logic                          w_cap;
  for (genvar k = 0; k < BLOCK_INST_SIZE; k++) begin : g_lane
    logic [6:0]  w_op;
    logic [20:0] w_imm;
    assign w_op    = r_data[32*k +: 7];
    assign w_imm   = {r_data[32*k+31], r_data[32*k+12 +: 8], r_data[32*k+20], r_data[32*k+21 +: 10], 1'b0};
    assign w_jal[k]  = w_op == 7'b1101111;
    assign w_none[k] = !w_jal[k] && w_op != 7'b1100111 && w_op != 7'b1100011;
    assign w_tgt[k]  = r_pc + VADDR_SIZE'(4*k) + VADDR_SIZE'($signed(w_imm));
  end
  always_comb begin
    logic done;
    done    = 1'b0;
    w_hit   = 1'b0;
    w_mask  = r_en;
    w_rpc   = '0;
    w_rsize = '0;
    for (int k = 0; k < BLOCK_INST_SIZE; k++) begin
      if (!done && r_en[k]) begin
        if (r_exc[k]) begin
          done = 1'b1;
        end else if (w_jal[k] && PREDICTION_WIDTH'(k) < r_size) begin
          done    = 1'b1;
          w_hit   = 1'b1;
          w_mask  = r_en & ~({BLOCK_INST_SIZE{1'b1}} << (k + 1));
          w_rpc   = w_tgt[k];
          w_rsize = PREDICTION_WIDTH'(k);
        end else if (PREDICTION_WIDTH'(k) == r_size) begin
          done    = 1'b1;
          w_hit   = r_taken ? (w_none[k] || (w_jal[k] && w_tgt[k] != r_target)) : w_jal[k];
          w_rpc   = w_none[k] ? r_pc + VADDR_SIZE'(4*(k+1)) : w_tgt[k];
          w_rsize = r_size;
        end
      end
    end
  end
  assign stall            = r_valid && !ibuf_ready;
  assign w_cap            = |in_en && !stall;
  assign out_en           = (r_valid && !flush) ? w_mask : '0;
  assign out_exception    = r_valid ? r_exc : '0;
  assign out_data         = r_data;
  assign out_pc           = r_pc;
  assign out_fsq_idx      = r_fsq;
  assign redirect_valid   = r_valid && w_hit && ibuf_ready && !flush;
  assign redirect_fsq_idx = r_fsq;
  assign redirect_pc      = w_rpc;
  assign redirect_size    = w_rsize;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_en     <= '0;
      r_exc    <= '0;
      r_data   <= '0;
      r_pc     <= '0;
      r_target <= '0;
      r_size   <= '0;
      r_taken  <= 1'b0;
      r_fsq    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_valid  <= 1'b1;
      r_en     <= in_en;
      r_exc    <= in_exception;
      r_data   <= in_data;
      r_pc     <= in_start_addr;
      r_target <= in_target;
      r_size   <= in_size;
      r_taken  <= in_taken;
      r_fsq    <= in_fsq_idx;
    end else if (r_valid && ibuf_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule
